// File: rtl/mul_div_unit_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Op codes, FSM states and step modes.
package mul_div_unit_pkg;

  localparam int MD_WORD_WIDTH = 32;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } md_mode_e;

  function automatic logic is_arith_op(
    input logic [2:0] op
  );
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

  function automatic logic is_signed_op(
    input logic [2:0] op
  );
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic is_div_op(
    input logic [2:0] op
  );
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit_step.sv
// One iteration of shift-add multiply or restoring divide.
// acc = {rem/prod-high (W+1), quot/prod-low (W)}.
module md_step
  import mul_div_unit_pkg::*;
#(
  parameter int WORD_WIDTH = MD_WORD_WIDTH
) (
  input  logic [2*WORD_WIDTH:0]  acc_in,
  input  logic [WORD_WIDTH-1:0]  operand,
  input  md_mode_e               mode,
  output logic [2*WORD_WIDTH:0]  acc_out
);

  localparam int W = WORD_WIDTH;

  logic [W-1:0] addend;
  logic [W:0]   sum;
  logic [W:0]   shl;
  logic [W+1:0] diff;
  logic         unused_top;

  assign unused_top = acc_in[2*W];

  // add-shift for multiply, trial-subtract-shift for divide
  always_comb begin
    addend  = acc_in[0] ? operand : {W{1'b0}};
    sum     = {1'b0, acc_in[2*W-1:W]} + {1'b0, addend};
    shl     = {acc_in[2*W-1:W], acc_in[W-1]};
    diff    = {1'b0, shl} - {2'b00, operand};
    acc_out = '0;
    unique case (mode)
      MODE_MUL: acc_out = {1'b0, sum, acc_in[W-1:1]};
      MODE_DIV: begin
        if (diff[W+1])
          acc_out = {shl, acc_in[W-2:0], 1'b0};
        else
          acc_out = {diff[W:0], acc_in[W-2:0], 1'b1};
      end
      default: acc_out = '0;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Magnitude datapath; signs are fixed up in a final cycle.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WORD_WIDTH = MD_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            mdOp,
  input  logic [WORD_WIDTH-1:0] inA,
  input  logic [WORD_WIDTH-1:0] inB,
  input  logic                  cancel,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] hi,
  output logic [WORD_WIDTH-1:0] lo
);

  localparam int W  = WORD_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  md_state_e      state;
  md_state_e      state_nx;
  md_mode_e       mode;
  logic [CW-1:0]  cnt;
  logic [2*W:0]   acc;
  logic [2*W:0]   acc_nx;
  logic [W-1:0]   opnd;
  logic [W-1:0]   a_raw;
  logic           neg_q;
  logic           neg_r;
  logic           div0;

  logic           sgn;
  logic           op_div;
  logic           sa;
  logic           sb;
  logic [W-1:0]   abs_a;
  logic [W-1:0]   abs_b;
  logic           accept;
  logic           launch;

  logic [2*W-1:0] prod;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot;
  logic [W-1:0]   rem;
  logic [W-1:0]   hi_fix;
  logic [W-1:0]   lo_fix;
  logic           unused_acc;

  assign unused_acc = acc[2*W];

  md_step #(
    .WORD_WIDTH (W)
  ) u_step (
    .acc_in  (acc),
    .operand (opnd),
    .mode    (mode),
    .acc_out (acc_nx)
  );

  // condition a new request: magnitudes, signs, accept
  always_comb begin
    sgn    = is_signed_op(mdOp);
    op_div = is_div_op(mdOp);
    sa     = sgn & inA[W-1];
    sb     = sgn & inB[W-1];
    abs_a  = sa ? -inA : inA;
    abs_b  = sb ? -inB : inB;
    accept = (state == S_IDLE) & start & ~cancel;
    launch = accept & is_arith_op(mdOp);
  end

  // sign correction of the finished magnitude result
  always_comb begin
    prod     = acc[2*W-1:0];
    prod_fix = neg_q ? -prod : prod;
    quot     = acc[W-1:0];
    rem      = acc[2*W-1:W];
    hi_fix   = prod_fix[2*W-1:W];
    lo_fix   = prod_fix[W-1:0];
    if (mode == MODE_DIV) begin
      hi_fix = neg_r ? -rem : rem;
      lo_fix = neg_q ? -quot : quot;
      if (div0) begin
        hi_fix = a_raw;
        lo_fix = {W{1'b1}};
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  // FSM next state; cancel beats completion
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (launch) state_nx = S_RUN;
      S_RUN: begin
        if (cancel)
          state_nx = S_IDLE;
        else if (cnt == CNT_LAST)
          state_nx = S_FIX;
      end
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // datapath, HI/LO and registered status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      acc   <= '0;
      opnd  <= '0;
      a_raw <= '0;
      mode  <= MODE_MUL;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept && mdOp == MD_MTHI)
            hi <= inA;
          if (accept && mdOp == MD_MTLO)
            lo <= inA;
          if (launch) begin
            mode  <= op_div ? MODE_DIV : MODE_MUL;
            opnd  <= op_div ? abs_b : abs_a;
            acc   <= {{(W+1){1'b0}},
                      op_div ? abs_a : abs_b};
            a_raw <= inA;
            div0  <= op_div & (inB == '0);
            neg_q <= sa ^ sb;
            neg_r <= sa;
            cnt   <= CNT_INIT;
            busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (cancel) begin
            busy <= 1'b0;
            cnt  <= '0;
          end else begin
            acc <= acc_nx;
            cnt <= cnt - 1'b1;
          end
        end
        S_FIX: begin
          busy <= 1'b0;
          if (!cancel) begin
            hi   <= hi_fix;
            lo   <= lo_fix;
            done <= 1'b1;
          end
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit (WORD_WIDTH=32).
// Vector table plus hand sequences for cancel/reset.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   mdOp;
  logic [W-1:0] inA;
  logic [W-1:0] inB;
  logic         cancel;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_vec;
  int n_bad;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[14];

  mul_div_unit #(
    .WORD_WIDTH (W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mdOp   (mdOp),
    .inA    (inA),
    .inB    (inB),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  task automatic run_op(
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output int           bcyc,
    output int           dcnt
  );
    @(negedge clk);
    start = 1'b1;
    mdOp  = op;
    inA   = a;
    inB   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    inA   = $urandom;
    inB   = $urandom;
    bcyc  = 0;
    dcnt  = 0;
    while (busy && bcyc < 100) begin
      bcyc++;
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    @(posedge clk);
    #1;
    if (done) dcnt++;
  endtask

  task automatic op1(
    input logic [2:0]   op,
    input logic [W-1:0] a
  );
    @(negedge clk);
    start = 1'b1;
    mdOp  = op;
    inA   = a;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    int bc;
    int dc;
    logic [W-1:0] h0;
    logic [W-1:0] l0;

    n_vec  = 0;
    n_bad  = 0;
    rst_n  = 1'b1;
    start  = 1'b0;
    mdOp   = MD_NOP;
    inA    = '0;
    inB    = '0;
    cancel = 1'b0;

    vecs[0]  = '{MD_MULT,  32'hFFFFFFFE, 32'h00000003,
                 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002,
                 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{MD_DIVU,  32'd7, 32'd2, 32'd1, 32'd3};
    vecs[4]  = '{MD_DIVU,  32'd7, 32'd0,
                 32'd7, 32'hFFFFFFFF};
    vecs[5]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF,
                 32'h00000000, 32'h80000000};
    vecs[6]  = '{MD_MULT,  32'd7, 32'hFFFFFFFD,
                 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[7]  = '{MD_DIV,   32'd100, 32'hFFFFFFF9,
                 32'd2, 32'hFFFFFFF2};
    vecs[8]  = '{MD_DIV,   32'hFFFFFF9C, 32'hFFFFFFF9,
                 32'hFFFFFFFE, 32'd14};
    vecs[9]  = '{MD_DIV,   32'hFFFFFFFB, 32'd0,
                 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[10] = '{MD_MULTU, 32'h00010000, 32'h00010000,
                 32'd1, 32'd0};
    vecs[11] = '{MD_MULT,  32'h80000000, 32'h80000000,
                 32'h40000000, 32'd0};
    vecs[12] = '{MD_DIVU,  32'hFFFFFFFF, 32'h10,
                 32'hF, 32'h0FFFFFFF};
    vecs[13] = '{MD_MULTU, 32'd0, 32'd5, 32'd0, 32'd0};

    // reset state
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // table vectors
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, bc, dc);
      chk($sformatf("v%0d_busy", i), 64'(bc), 64'd33);
      chk($sformatf("v%0d_done", i), 64'(dc), 64'd1);
      chk($sformatf("v%0d_hi", i), 64'(hi),
          64'(vecs[i].hi));
      chk($sformatf("v%0d_lo", i), 64'(lo),
          64'(vecs[i].lo));
    end

    // MTHI / MTLO: one edge, no busy, no done
    op1(MD_MTHI, 32'h1234);
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_busy", 64'(busy), 64'd0);
    chk("mthi_done", 64'(done), 64'd0);
    op1(MD_MTLO, 32'h5678);
    chk("mtlo_lo", 64'(lo), 64'h5678);
    chk("mtlo_hi", 64'(hi), 64'h1234);

    // start while busy is ignored
    @(negedge clk);
    start = 1'b1;
    mdOp  = MD_MULT;
    inA   = 32'd5;
    inB   = 32'd6;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    mdOp  = MD_MULT;
    inA   = 32'd9;
    inB   = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    bc = 0;
    while (busy && bc < 100) begin
      bc++;
      @(posedge clk);
    end
    #1;
    chk("ign_lo", 64'(lo), 64'd30);
    chk("ign_hi", 64'(hi), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("ign_busy", 64'(busy), 64'd0);

    // cancel in RUN at cycle 10
    @(negedge clk);
    start = 1'b1;
    mdOp  = MD_MULT;
    inA   = 32'hFFFFFFFF;
    inB   = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    chk("can_busy", 64'(busy), 64'd0);
    chk("can_done", 64'(done), 64'd0);
    dc = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) dc++;
    end
    chk("can_later", 64'(dc), 64'd0);
    chk("can_hi", 64'(hi), 64'd0);
    chk("can_lo", 64'(lo), 64'd30);

    // cancel in FIX drops the write
    @(negedge clk);
    start = 1'b1;
    mdOp  = MD_DIVU;
    inA   = 32'd100;
    inB   = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (W) @(posedge clk);
    @(negedge clk);
    chk("fix_busy_pre", 64'(busy), 64'd1);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    chk("fix_busy", 64'(busy), 64'd0);
    chk("fix_done", 64'(done), 64'd0);
    chk("fix_hi", 64'(hi), 64'd0);
    chk("fix_lo", 64'(lo), 64'd30);

    // cancel in IDLE drops start, MTHI included
    @(negedge clk);
    cancel = 1'b1;
    start  = 1'b1;
    mdOp   = MD_MTHI;
    inA    = 32'hDEAD;
    @(posedge clk);
    #1;
    chk("cidle_hi", 64'(hi), 64'd0);
    @(negedge clk);
    mdOp = MD_MULT;
    @(posedge clk);
    #1;
    start  = 1'b0;
    cancel = 1'b0;
    chk("cidle_busy", 64'(busy), 64'd0);

    // async reset mid-DIV
    run_op(MD_MTHI, 32'hAAAA, 32'd0, bc, dc);
    h0 = hi;
    l0 = lo;
    chk("pre_rst_hi", 64'(h0), 64'hAAAA);
    @(negedge clk);
    start = 1'b1;
    mdOp  = MD_DIVU;
    inA   = 32'd7;
    inB   = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(MD_MULT, 32'd3, 32'd4, bc, dc);
    chk("post_busy", 64'(bc), 64'd33);
    chk("post_done", 64'(dc), 64'd1);
    chk("post_lo", 64'(lo), 64'd12);
    chk("post_hi", 64'(hi), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
